// File: rtl/game_sequencer_if.sv
// Game sequencer bus: keyboard byte in; scene, bird, pipes, score out.
// master drives inp, slave (the sequencer) drives the game state.
interface game_sequencer_if;
  logic [7:0]  inp;
  logic [1:0]  scene;
  logic [8:0]  bird;
  logic [71:0] gaps;
  logic [7:0]  score;

  modport master (
    output inp,
    input  scene, bird, gaps, score
  );

  modport slave (
    input  inp,
    output scene, bird, gaps, score
  );
endinterface

// File: rtl/game_sequencer.sv
// Flappy-style game sequencer: splash/play/gameover FSM, bird, 3 pipes, score.
// Ports: clk, rst (sync, active-high), bus (slave: inp in; scene/bird/gaps/score out).
module game_sequencer #(
  parameter int TICK_DIV    = 4,
  parameter int HEIGHT      = 40,
  parameter int GAP         = 10,
  parameter int RESPAWN_POS = 60
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    SPLASH   = 2'd0,
    PLAYING  = 2'd1,
    GAMEOVER = 2'd2
  } scene_e;

  typedef struct packed {
    logic [7:0] pos;
    logic [7:0] max_b;
    logic [7:0] min_b;
  } pipe_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
  localparam logic [7:0] ALT_MAX = 8'(HEIGHT - 1);
  localparam logic [7:0] GAP_W = 8'(GAP);
  localparam logic [7:0] RESP_W = 8'(RESPAWN_POS);
  localparam logic [7:0] ALT_INIT = 8'd20;
  localparam pipe_t [2:0] PIPES_INIT = {
    8'd20, 8'd30, 8'd20,
    8'd40, 8'd25, 8'd15,
    8'd60, 8'd35, 8'd25
  };

  scene_e      scene_q, scene_d;
  logic [7:0]  alt_q, alt_d;
  logic        flap_q;
  logic [4:0]  fbuf_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  score_q, score_d;
  logic [7:0]  lfsr_q;
  pipe_t [2:0] pipes_q, pipes_d;

  logic space, quit, hit, collide, tick, adv;
  logic go_play, go_over, go_splash;
  logic [1:0] n_resp;
  logic [8:0] score_sum;
  logic [7:0] new_min;

  assign space = (bus.inp == 8'd32);
  assign quit  = (bus.inp == 8'd120);
  assign tick  = (scene_q == PLAYING) && (cnt_q == TMAX);

  always_comb begin
    hit = (alt_q == 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (pipes_q[i].pos <= 8'd8 &&
          (alt_q >= pipes_q[i].max_b ||
           alt_q <= pipes_q[i].min_b))
        hit = 1'b1;
    end
  end

  assign collide = (scene_q == PLAYING) && hit;

  always_comb begin
    scene_d   = scene_q;
    go_play   = 1'b0;
    go_over   = 1'b0;
    go_splash = 1'b0;
    case (scene_q)
      SPLASH: if (space) begin
        scene_d = PLAYING;
        go_play = 1'b1;
      end
      PLAYING: if (quit || collide) begin
        scene_d = GAMEOVER;
        go_over = 1'b1;
      end
      GAMEOVER: if (space) begin
        scene_d   = SPLASH;
        go_splash = 1'b1;
      end
      default: scene_d = SPLASH;
    endcase
  end

  // Leaving PLAYING on this cycle discards the tick.
  assign adv = tick && !go_over;

  assign new_min = 8'd8 + {4'd0, lfsr_q[3:0]};

  always_comb begin
    pipes_d = pipes_q;
    n_resp  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (pipes_q[i].pos == 8'd0) begin
        pipes_d[i].pos   = RESP_W;
        pipes_d[i].min_b = new_min;
        pipes_d[i].max_b = new_min + GAP_W;
        n_resp = n_resp + 2'd1;
      end else begin
        pipes_d[i].pos = pipes_q[i].pos - 8'd1;
      end
    end
  end

  assign score_sum = {1'b0, score_q} + {7'd0, n_resp};
  assign score_d   = score_sum[8] ? 8'd255 : score_sum[7:0];

  always_comb begin
    alt_d = alt_q;
    unique case (1'b1)
      (flap_q && alt_q != ALT_MAX): alt_d = alt_q + 8'd1;
      (!flap_q && alt_q != 8'd0):   alt_d = alt_q - 8'd1;
      default:                      alt_d = alt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) scene_q <= SPLASH;
    else     scene_q <= scene_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= 8'h5A;
      cnt_q   <= '0;
      fbuf_q  <= '0;
      flap_q  <= 1'b0;
      alt_q   <= ALT_INIT;
      score_q <= 8'd0;
      pipes_q <= PIPES_INIT;
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (scene_q == PLAYING && !go_over && !tick)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;
      if (go_splash) begin
        fbuf_q  <= '0;
        flap_q  <= 1'b0;
        alt_q   <= ALT_INIT;
        score_q <= 8'd0;
        pipes_q <= PIPES_INIT;
      end else begin
        fbuf_q <= {space && scene_q == PLAYING, fbuf_q[4:1]};
        flap_q <= |fbuf_q;
        if (go_play) score_q <= 8'd0;
        if (adv) begin
          alt_q   <= alt_d;
          pipes_q <= pipes_d;
          score_q <= score_d;
        end
      end
    end
  end

  assign bus.scene = scene_q;
  assign bus.bird  = {alt_q, flap_q};
  assign bus.gaps  = pipes_q;
  assign bus.score = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector table plus a full-game sequence.
// dut_a uses defaults; dut_b has HEIGHT=22 so continuous flapping saturates in-gap.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_sequencer_if if_a ();
  game_sequencer_if if_b ();

  game_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  game_sequencer #(.HEIGHT(22)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  typedef struct {
    int         n;
    logic       rst;
    logic [7:0] inp;
    logic [1:0] scene;
    logic [7:0] alt;
    logic       flap;
    logic [7:0] score;
    logic [71:0] gaps;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [71:0] gp(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic [7:0] c);
    return {a, 8'd30, 8'd20, b, 8'd25, 8'd15, c, 8'd35, 8'd25};
  endfunction

  function automatic vec_t mk(input int n, input logic r,
                              input logic [7:0] i,
                              input logic [1:0] s,
                              input logic [7:0] a,
                              input logic f,
                              input logic [7:0] sc,
                              input logic [71:0] g);
    vec_t v;
    v.n = n; v.rst = r; v.inp = i; v.scene = s;
    v.alt = a; v.flap = f; v.score = sc; v.gaps = g;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [7:0] i);
    rst = r;
    if_a.inp = i;
    if_b.inp = i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [71:0] gr;
    logic [7:0] mn;
    gr = gp(20, 40, 60);
    rst = 1'b1;
    if_a.inp = 8'd0;
    if_b.inp = 8'd0;

    tbl.push_back(mk(2,   1, 0,   0, 20, 0, 0, gr));
    tbl.push_back(mk(100, 0, 0,   0, 20, 0, 0, gr));
    tbl.push_back(mk(3,   0, 120, 0, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 0,   1, 20, 1, 0, gr));
    tbl.push_back(mk(2,   0, 0,   1, 21, 1, 0, gp(19, 39, 59)));
    tbl.push_back(mk(2,   0, 0,   1, 21, 1, 0, gp(19, 39, 59)));
    tbl.push_back(mk(1,   0, 0,   1, 21, 0, 0, gp(19, 39, 59)));
    tbl.push_back(mk(1,   0, 0,   1, 20, 0, 0, gp(18, 38, 58)));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gp(18, 38, 58)));
    tbl.push_back(mk(3,   0, 0,   1, 21, 1, 0, gp(17, 37, 57)));
    tbl.push_back(mk(1,   0, 32,  1, 21, 1, 0, gp(17, 37, 57)));
    tbl.push_back(mk(3,   0, 0,   1, 22, 1, 0, gp(16, 36, 56)));
    tbl.push_back(mk(1,   0, 32,  1, 22, 1, 0, gp(16, 36, 56)));
    tbl.push_back(mk(3,   0, 0,   1, 23, 1, 0, gp(15, 35, 55)));
    tbl.push_back(mk(4,   0, 0,   1, 22, 0, 0, gp(14, 34, 54)));
    tbl.push_back(mk(24,  0, 0,   1, 16, 0, 0, gp(8, 28, 48)));
    tbl.push_back(mk(1,   0, 0,   2, 16, 0, 0, gp(8, 28, 48)));
    tbl.push_back(mk(20,  0, 0,   2, 16, 0, 0, gp(8, 28, 48)));
    tbl.push_back(mk(3,   0, 120, 2, 16, 0, 0, gp(8, 28, 48)));
    tbl.push_back(mk(1,   0, 32,  0, 20, 0, 0, gr));
    tbl.push_back(mk(10,  0, 0,   0, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(3,   0, 0,   1, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 120, 2, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  0, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(5,   0, 0,   1, 21, 1, 0, gp(19, 39, 59)));
    tbl.push_back(mk(1,   1, 32,  0, 20, 0, 0, gr));
    tbl.push_back(mk(4,   0, 0,   0, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 32,  1, 20, 0, 0, gr));
    tbl.push_back(mk(3,   0, 0,   1, 20, 0, 0, gr));
    tbl.push_back(mk(1,   0, 0,   1, 19, 0, 0, gp(19, 39, 59)));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].rst, tbl[i].inp);
      chk($sformatf("v%0d_scene", i), 72'(if_a.scene), 72'(tbl[i].scene));
      chk($sformatf("v%0d_alt", i), 72'(if_a.bird[8:1]), 72'(tbl[i].alt));
      chk($sformatf("v%0d_flap", i), 72'(if_a.bird[0]), 72'(tbl[i].flap));
      chk($sformatf("v%0d_score", i), 72'(if_a.score), 72'(tbl[i].score));
      chk($sformatf("v%0d_gaps", i), if_a.gaps, tbl[i].gaps);
    end

    cyc(1, 0);
    cyc(1, 0);
    for (int e = 0; e <= 210; e++) begin
      cyc(0, 32);
      if (e >= 4 && e <= 208 && (e % 4) == 0)
        chk($sformatf("b_alt_cap_e%0d", e),
            72'(if_b.bird[8:1] <= 8'd21), 72'(1));
      if (e == 4) begin
        chk("b_alt_t1", 72'(if_b.bird[8:1]), 72'(21));
        chk("b_scene_t1", 72'(if_b.scene), 72'(1));
      end
      if (e == 80) begin
        chk("b_p1pos_t20", 72'(if_b.gaps[71:64]), 72'(0));
        chk("b_score_t20", 72'(if_b.score), 72'(0));
        chk("b_alt_t20", 72'(if_b.bird[8:1]), 72'(21));
      end
      if (e == 84) begin
        mn = if_b.gaps[55:48];
        chk("b_p1pos_resp", 72'(if_b.gaps[71:64]), 72'(60));
        chk("b_p1min_range", 72'(mn >= 8'd8 && mn <= 8'd23), 72'(1));
        chk("b_p1max", 72'(if_b.gaps[63:56]), 72'(mn + 8'd10));
        chk("b_score_1", 72'(if_b.score), 72'(1));
        chk("b_p2pos_t21", 72'(if_b.gaps[47:40]), 72'(19));
        chk("b_scene_t21", 72'(if_b.scene), 72'(1));
      end
      if (e == 164) begin
        chk("b_score_2", 72'(if_b.score), 72'(2));
        chk("b_p2pos_resp", 72'(if_b.gaps[47:40]), 72'(60));
      end
      if (e == 208) begin
        chk("b_p3pos_8", 72'(if_b.gaps[23:16]), 72'(8));
        chk("b_scene_pre", 72'(if_b.scene), 72'(1));
      end
      if (e == 209) begin
        chk("b_scene_over", 72'(if_b.scene), 72'(2));
        chk("b_score_keep", 72'(if_b.score), 72'(2));
        chk("b_alt_keep", 72'(if_b.bird[8:1]), 72'(21));
      end
      if (e == 210) begin
        chk("b_scene_splash", 72'(if_b.scene), 72'(0));
        chk("b_gaps_reinit", if_b.gaps, gr);
        chk("b_score_reinit", 72'(if_b.score), 72'(0));
        chk("b_alt_reinit", 72'(if_b.bird[8:1]), 72'(20));
      end
    end
    cyc(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
